memory_access_stage: RTL and testbench

//   M stage of the 5-stage pipeline. Takes the M-side outputs of the execute stage
//   (ALU_ResultM, WriteDataM, MemWriteM, ResultSrcM, RegWriteM, RD_M, PCPlus4M)
//   and issues loads/stores on a variable-latency req/ack data-memory bus.

---
 rtl/memory_access_stage_if.sv | 42 ++++
 rtl/memory_access_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
//   Request/acknowledge data-memory bus used by the M stage.
//
//   Signals
//     mem_req    request, held by the requester until mem_ack
//     mem_we     1 = write, 0 = read
//     mem_addr   word-aligned byte address
//     mem_wdata  write data
//     mem_rdata  read data, valid in the cycle mem_ack is high
//     mem_ack    one-cycle completion pulse from the memory
//
//   Modports
//     master  pipeline side (drives request, address, data)
//     slave   memory side (drives read data and acknowledge)
// -----------------------------------------------------------------------------
interface memory_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//   M stage of the 5-stage pipeline. Issues loads and stores from the execute
//   stage outputs onto a variable-latency req/ack data-memory bus, stalls the
//   upstream stages while an access is outstanding, aborts an access that is
//   not acknowledged in time, and registers results into the M/W register.
//
//   Parameters
//     TIMEOUT_CYCLES  wait cycles after issue before an access is aborted
//
//   Build option
//     MEM_MISALIGN_TRAP_EN  when defined, an access whose byte address has
//                           nonzero low bits is not issued; it is reported as
//                           mem_err with code 2'b10 instead. When undefined
//                           the low address bits are simply dropped.
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous reset, active low
//     RegWriteM      instruction writes rd
//     MemWriteM      store
//     ResultSrcM     1 = load (result from memory), 0 = ALU result
//     RD_M           destination register
//     PCPlus4M       PC+4 passthrough
//     ALU_ResultM    ALU result / memory byte address
//     WriteDataM     store data
//     dmem           data-memory bus (master side)
//     StallM         freeze PC, F/D, D/E and E/M registers
//     RegWriteW      W-stage write enable
//     ResultSrcW     W-stage result select
//     RD_W           W-stage destination register
//     PCPlus4W       W-stage PC+4
//     ALU_ResultW    W-stage ALU result
//     ReadDataW      W-stage load data
//     mem_err        one-cycle pulse: access aborted
//     mem_err_code   2'b01 timeout, 2'b10 misaligned; valid with mem_err
// -----------------------------------------------------------------------------
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         RegWriteM,
    input  logic                         MemWriteM,
    input  logic                         ResultSrcM,
    input  logic [4:0]                   RD_M,
    input  logic [31:0]                  PCPlus4M,
    input  logic [31:0]                  ALU_ResultM,
    input  logic [31:0]                  WriteDataM,

    memory_access_stage_if.master        dmem,

    output logic                         StallM,
    output logic                         RegWriteW,
    output logic                         ResultSrcW,
    output logic [4:0]                   RD_W,
    output logic [31:0]                  PCPlus4W,
    output logic [31:0]                  ALU_ResultW,
    output logic [31:0]                  ReadDataW,
    output logic                         mem_err,
    output logic [1:0]                   mem_err_code
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] COUNT_ZERO  = '0;
    localparam logic [CW-1:0] COUNT_ONE   = CW'(1);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;

    logic          reg_write_w_reg;
    logic          result_src_w_reg;
    logic [4:0]    rd_w_reg;
    logic [31:0]   pc_plus4_w_reg;
    logic [31:0]   alu_result_w_reg;
    logic [31:0]   read_data_w_reg;
    logic          mem_err_reg;
    logic [1:0]    mem_err_code_reg;

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic        access;
    logic        is_load;
    logic        misalign;
    logic        issue;
    logic [31:0] addr_aligned;
    logic [31:0] read_data_next;

    // A store that also claims a memory result is treated as a store, so only
    // a pure ResultSrcM instruction captures read data.
    assign access  = MemWriteM | ResultSrcM;
    assign is_load = ResultSrcM & ~MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = |ALU_ResultM[1:0];
`else
    assign misalign = 1'b0;
`endif

    // Accesses that actually go out on the bus.
    assign issue = access & ~misalign;

    // Word-aligned bus address: byte-offset bits forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_addr_align
            if (gi < 2) begin : g_low
                assign addr_aligned[gi] = 1'b0;
            end else begin : g_high
                assign addr_aligned[gi] = ALU_ResultM[gi];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Bus request and stall
    // -------------------------------------------------------------------------
    logic req;
    logic ack;
    logic complete;
    logic stall;
    logic at_limit;
    logic abort;
    logic trap;

    // The request is gated by rst so that asserting reset in the middle of an
    // outstanding access drops the request and the stall without waiting for
    // a clock edge, even while the E/M register still presents the access.
    assign req = rst & ((state_reg == WAIT) | ((state_reg == IDLE) & issue));

    // An acknowledge with no request outstanding is ignored.
    assign ack      = dmem.mem_ack & req;
    assign complete = ack;
    assign stall    = req & ~dmem.mem_ack;

    // An acknowledge in the same cycle the counter hits its limit completes
    // the access; the timeout is only taken when no acknowledge arrives.
    assign at_limit = (count_reg == COUNT_LIMIT);
    assign abort    = (state_reg == WAIT) & ~dmem.mem_ack & at_limit;

    // Misaligned access under the trap option: never issued, reported on the
    // next edge. In WAIT the inputs are held, so only IDLE can trap.
    assign trap = (state_reg == IDLE) & access & misalign;

    assign dmem.mem_req   = req;
    assign dmem.mem_we    = req & MemWriteM;
    assign dmem.mem_addr  = req ? addr_aligned : 32'd0;
    assign dmem.mem_wdata = req ? WriteDataM   : 32'd0;

    assign StallM = stall;

    // -------------------------------------------------------------------------
    // Access FSM and wait counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                // Zero-wait completions never leave IDLE.
                if (stall) begin
                    state_next = WAIT;
                    count_next = COUNT_ONE;
                end
            end
            WAIT: begin
                if (dmem.mem_ack) begin
                    state_next = IDLE;
                    count_next = COUNT_ZERO;
                end else if (at_limit) begin
                    state_next = IDLE;
                    count_next = COUNT_ZERO;
                end else begin
                    count_next = count_reg + COUNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = COUNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= COUNT_ZERO;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // M/W pipeline register
    // -------------------------------------------------------------------------
    assign read_data_next = is_load ? dmem.mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_reg  <= 1'b0;
            result_src_w_reg <= 1'b0;
            rd_w_reg         <= 5'd0;
            pc_plus4_w_reg   <= 32'd0;
            alu_result_w_reg <= 32'd0;
            read_data_w_reg  <= 32'd0;
        end else if (stall | trap) begin
            // Bubble: suppress the register write, keep the other fields.
            // The abort cycle is also a stall cycle, so it bubbles here too.
            reg_write_w_reg  <= 1'b0;
        end else begin
            reg_write_w_reg  <= RegWriteM;
            result_src_w_reg <= ResultSrcM;
            rd_w_reg         <= RD_M;
            pc_plus4_w_reg   <= PCPlus4M;
            alu_result_w_reg <= ALU_ResultM;
            read_data_w_reg  <= complete ? read_data_next : 32'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Error reporting: one-cycle pulse on the edge after the abort decision
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err_reg      <= 1'b0;
            mem_err_code_reg <= ERR_NONE;
        end else begin
            mem_err_reg <= abort | trap;
            if (abort) begin
                mem_err_code_reg <= ERR_TIMEOUT;
            end else if (trap) begin
                mem_err_code_reg <= ERR_MISALIGN;
            end else begin
                mem_err_code_reg <= ERR_NONE;
            end
        end
    end

    assign RegWriteW    = reg_write_w_reg;
    assign ResultSrcW   = result_src_w_reg;
    assign RD_W         = rd_w_reg;
    assign PCPlus4W     = pc_plus4_w_reg;
    assign ALU_ResultW  = alu_result_w_reg;
    assign ReadDataW    = read_data_w_reg;
    assign mem_err      = mem_err_reg;
    assign mem_err_code = mem_err_code_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//   Self-checking bench for memory_access_stage with TIMEOUT_CYCLES = 4.
//   Expected W-register contents are computed from the driven instruction and
//   queued; they are popped and compared when the stage retires it.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

    localparam int T = 4;
    localparam logic [31:0] NOP_ALU = 32'h0000_00A5;

    typedef struct packed {
        logic        rw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
    } w_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM, RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        mem_err;
    logic [1:0]  mem_err_code;

    int checks   = 0;
    int failures = 0;
    w_t exp_q[$];
    w_t nop_w;

    memory_access_stage_if bus ();

    memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .ResultSrcM   (ResultSrcM),
        .RD_M         (RD_M),
        .PCPlus4M     (PCPlus4M),
        .ALU_ResultM  (ALU_ResultM),
        .WriteDataM   (WriteDataM),
        .dmem         (bus.master),
        .StallM       (StallM),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW),
        .RD_W         (RD_W),
        .PCPlus4W     (PCPlus4W),
        .ALU_ResultW  (ALU_ResultW),
        .ReadDataW    (ReadDataW),
        .mem_err      (mem_err),
        .mem_err_code (mem_err_code)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic ms, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM   = rw;
        MemWriteM   = ms;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        ALU_ResultM = alu;
        WriteDataM  = wd;
    endtask

    // Reference for what the W register must hold after retirement.
    function automatic w_t model(input logic rw, input logic ms, input logic rs, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata);
        w_t w;
        w.rw    = rw;
        w.rs    = rs;
        w.rd    = rd;
        w.pc    = pc;
        w.alu   = alu;
        w.rdata = (rs && !ms) ? rdata : 32'd0;
        return w;
    endfunction

    function automatic w_t w_now();
        w_t w;
        w = {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};
        return w;
    endfunction

    // Retire a non-access, non-writing instruction so W holds a known value.
    task automatic settle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, NOP_ALU, 32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        w_t act;
        rst = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h10, 32'h100, 32'd0);
        #2;
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got req=%b stall=%b exp 0 0", bus.mem_req, StallM);
        end
        tick();
        act = w_now();
        checks++;
        if (act !== '0 || mem_err !== 1'b0 || mem_err_code !== 2'b00) begin
            failures++;
            $display("FAIL reset_w got w=%h err=%b code=%b exp all zero", act, mem_err, mem_err_code);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, NOP_ALU, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        $display("reset: W=%h err=%b", w_now(), mem_err);
    endtask

    task automatic test_load_zero_wait();
        w_t act, e;
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h44, 32'h100, 32'd0);
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_ack   = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0, 1'b1, 5'd5, 32'h44, 32'h100, 32'hDEAD_BEEF));
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL load0_bus got stall=%b req=%b we=%b addr=%h exp 0 1 0 00000100",
                     StallM, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        tick();
        act = w_now();
        e   = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL load0_w got %h exp %h", act, e);
        end
        $display("load zero-wait: W=%h", act);
        settle();
    endtask

    task automatic test_store_wait();
        w_t act, e;
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h80, 32'h200, 32'h1234_5678);
        bus.mem_ack = 1'b0;
        exp_q.push_back(model(1'b0, 1'b1, 1'b0, 5'd7, 32'h80, 32'h200, 32'd0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (StallM !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_addr !== 32'h200) begin
                failures++;
                $display("FAIL store_wait_bus[%0d] got stall=%b we=%b wdata=%h addr=%h exp 1 1 12345678 00000200",
                         i, StallM, bus.mem_we, bus.mem_wdata, bus.mem_addr);
            end
            tick();
            act = w_now();
            checks++;
            if (act !== nop_w) begin
                failures++;
                $display("FAIL store_bubble[%0d] got %h exp %h", i, act, nop_w);
            end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || bus.mem_we !== 1'b1) begin
            failures++;
            $display("FAIL store_ack_bus got stall=%b we=%b exp 0 1", StallM, bus.mem_we);
        end
        tick();
        act = w_now();
        e   = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL store_w got %h exp %h", act, e);
        end
        $display("store 3-wait: W=%h", act);
        settle();
    endtask

    task automatic test_timeout();
        w_t act;
        drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h90, 32'h300, 32'd0);
        bus.mem_ack = 1'b0;
        for (int i = 0; i <= T; i++) begin
            @(negedge clk);
            checks++;
            if (StallM !== 1'b1) begin
                failures++;
                $display("FAIL timeout_stall[%0d] got %b exp 1", i, StallM);
            end
            tick();
            act = w_now();
            if (i < T) begin
                checks++;
                if (act !== nop_w || mem_err !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_wait[%0d] got w=%h err=%b exp w=%h err=0", i, act, mem_err, nop_w);
                end
            end
        end
        checks++;
        if (mem_err !== 1'b1 || mem_err_code !== 2'b01 || act !== nop_w) begin
            failures++;
            $display("FAIL timeout_err got err=%b code=%b w=%h exp 1 01 %h", mem_err, mem_err_code, act, nop_w);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, NOP_ALU, 32'd0);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL timeout_resume got req=%b stall=%b exp 0 0", bus.mem_req, StallM);
        end
        tick();
        checks++;
        if (mem_err !== 1'b0 || mem_err_code !== 2'b00) begin
            failures++;
            $display("FAIL timeout_pulse got err=%b code=%b exp 0 00", mem_err, mem_err_code);
        end
        $display("timeout: err pulse seen, W=%h", w_now());
    endtask

    task automatic test_ack_at_limit();
        w_t act, e;
        drive(1'b1, 1'b0, 1'b1, 5'd11, 32'hA0, 32'h340, 32'd0);
        bus.mem_ack = 1'b0;
        exp_q.push_back(model(1'b1, 1'b0, 1'b1, 5'd11, 32'hA0, 32'h340, 32'h0BAD_F00D));
        for (int i = 0; i < T; i++) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        act = w_now();
        e   = exp_q.pop_front();
        checks++;
        if (act !== e || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL ack_at_limit got w=%h err=%b exp w=%h err=0", act, mem_err, e);
        end
        $display("ack at limit: W=%h err=%b", act, mem_err);
        settle();
    endtask

    task automatic test_misalign();
        w_t act;
        drive(1'b1, 1'b0, 1'b1, 5'd12, 32'hB0, 32'h102, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL misalign_noreq got req=%b stall=%b exp 0 0", bus.mem_req, StallM);
        end
        tick();
        act = w_now();
        checks++;
        if (mem_err !== 1'b1 || mem_err_code !== 2'b10 || act !== nop_w) begin
            failures++;
            $display("FAIL misalign_trap got err=%b code=%b w=%h exp 1 10 %h", mem_err, mem_err_code, act, nop_w);
        end
`else
        exp_q.push_back(model(1'b1, 1'b0, 1'b1, 5'd12, 32'hB0, 32'h102, 32'hCAFE_F00D));
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL misalign_addr got req=%b addr=%h exp 1 00000100", bus.mem_req, bus.mem_addr);
        end
        tick();
        act = w_now();
        checks++;
        if (act !== exp_q[0] || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_w got w=%h err=%b exp w=%h err=0", act, mem_err, exp_q[0]);
        end
        void'(exp_q.pop_front());
`endif
        $display("misaligned 0x102: W=%h err=%b code=%b", act, mem_err, mem_err_code);
        settle();
    endtask

    task automatic test_reset_mid_wait();
        w_t act;
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'hC0, 32'h400, 32'd0);
        bus.mem_ack = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (StallM !== 1'b1 || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstwait_pre got stall=%b req=%b exp 1 1", StallM, bus.mem_req);
        end
        #1 rst = 1'b0;
        #1;
        act = w_now();
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0 || act !== '0 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_async got req=%b stall=%b w=%h err=%b exp 0 0 0 0",
                     bus.mem_req, StallM, act, mem_err);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, NOP_ALU, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_idle got req=%b stall=%b exp 0 0", bus.mem_req, StallM);
        end
        $display("reset mid-wait: req=%b stall=%b", bus.mem_req, StallM);
        settle();
    endtask

    task automatic test_alu_stray_ack();
        w_t act, e;
        drive(1'b1, 1'b0, 1'b0, 5'd4, 32'hD0, 32'd7, 32'h5555_5555);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        exp_q.push_back(model(1'b1, 1'b0, 1'b0, 5'd4, 32'hD0, 32'd7, 32'hFFFF_FFFF));
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL alu_noreq got req=%b stall=%b exp 0 0", bus.mem_req, StallM);
        end
        tick();
        act = w_now();
        e   = exp_q.pop_front();
        checks++;
        if (act !== e || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL alu_w got w=%h err=%b exp w=%h err=0", act, mem_err, e);
        end
        $display("alu op stray ack: W=%h", act);
        settle();
    endtask

    task automatic test_back_to_back();
        w_t act, e;
        logic rw, ms, rs;
        logic [4:0]  rd;
        logic [31:0] pc, alu, wd, rdata;
        int kind;
        for (int k = 0; k < 10; k++) begin
            kind  = int'($urandom_range(0, 2));
            rw    = (kind != 2);
            ms    = (kind == 2);
            rs    = (kind == 1);
            rd    = 5'($urandom_range(1, 31));
            pc    = $urandom;
            alu   = $urandom & 32'hFFFF_FFFC;
            wd    = $urandom;
            rdata = $urandom;
            drive(rw, ms, rs, rd, pc, alu, wd);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
            exp_q.push_back(model(rw, ms, rs, rd, pc, alu, rdata));
            @(negedge clk);
            checks++;
            if (StallM !== 1'b0 || bus.mem_req !== (ms | rs)) begin
                failures++;
                $display("FAIL b2b_bus[%0d] got stall=%b req=%b exp 0 %b", k, StallM, bus.mem_req, ms | rs);
            end
            tick();
            act = w_now();
            e   = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL b2b_w[%0d] got %h exp %h", k, act, e);
            end
            $display("b2b[%0d] kind=%0d W=%h", k, kind, act);
        end
        settle();
    endtask

    initial begin
        nop_w = model(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, NOP_ALU, 32'd0);
        test_reset();
        settle();
        test_load_zero_wait();
        test_store_wait();
        test_timeout();
        test_ack_at_limit();
        test_misalign();
        test_reset_mid_wait();
        test_alu_stray_ack();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
